// File: rtl/pre_io_pkg.sv
// Shared mode encodings and limits for the pre_io pad bank.
// Constants only; no logic lives here.
package pre_io_pkg;

    localparam int unsigned IN_COMB   = 0;
    localparam int unsigned IN_REG    = 1;
    localparam int unsigned IN_DDR    = 2;

    localparam int unsigned OUT_COMB  = 0;
    localparam int unsigned OUT_REG   = 1;
    localparam int unsigned OUT_DDR   = 2;

    localparam int unsigned OE_ALWAYS = 0;
    localparam int unsigned OE_DIRECT = 1;
    localparam int unsigned OE_REG    = 2;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned MAX_SYNC  = 3;

    function automatic bit mode_ok(input int unsigned mode);
        return mode <= 2;
    endfunction

endpackage

// File: rtl/pre_io_slice.sv
// One pad channel: optional synchroniser, input path (comb/reg/DDR) with
// input freeze, and output path (comb/reg/DDR).
module pre_io_slice
    import pre_io_pkg::*;
#(
    parameter int unsigned IN_MODE     = IN_REG,
    parameter int unsigned OUT_MODE    = OUT_REG,
    parameter int unsigned SYNC_STAGES = 0,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ce,
    input  logic i_latch,
    input  logic i_dout0,
    input  logic i_dout1,
    input  logic i_padin,
    output logic o_din0,
    output logic o_din1,
    output logic o_padout
);

    logic w_s;
    logic w_upd;

    assign w_upd = i_ce && !i_latch;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign w_s = i_padin;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] r_sync;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_sync <= '0;
            end else if (i_ce) begin
                r_sync <= (r_sync << 1) | SYNC_STAGES'(i_padin);
            end
        end
        assign w_s = r_sync[SYNC_STAGES-1];
    end

    if (IN_MODE == IN_COMB) begin : g_in_comb
        // Live path has no flop, so a hold register provides the frozen value.
        logic r_hold;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_hold <= 1'b0;
            end else if (w_upd) begin
                r_hold <= w_s;
            end
        end
        assign o_din0 = i_latch ? r_hold : w_s;
        assign o_din1 = 1'b0;
    end else if (IN_MODE == IN_REG) begin : g_in_reg
        logic r_in;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_in <= 1'b0;
            end else if (w_upd) begin
                r_in <= w_s;
            end
        end
        assign o_din0 = r_in;
        assign o_din1 = 1'b0;
    end else begin : g_in_ddr
        logic r_rise;
        logic r_fall;
        logic r_d0;
        logic r_d1;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_rise <= 1'b0;
                r_d0   <= 1'b0;
                r_d1   <= 1'b0;
            end else if (i_ce) begin
                r_rise <= w_s;
                if (!i_latch) begin
                    r_d0 <= r_rise;
                    r_d1 <= r_fall;
                end
            end
        end
        always_ff @(negedge i_clk) begin
            if (i_rst) begin
                r_fall <= 1'b0;
            end else if (i_ce) begin
                r_fall <= w_s;
            end
        end
        assign o_din0 = r_d0;
        assign o_din1 = r_d1;
    end

    if (OUT_MODE == OUT_COMB) begin : g_out_comb
        logic w_unused_out;
        assign w_unused_out = i_dout1 ^ RESET_VAL;
        assign o_padout     = i_dout0;
    end else if (OUT_MODE == OUT_REG) begin : g_out_reg
        logic r_q0;
        logic w_unused_dout1;
        assign w_unused_dout1 = i_dout1;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_q0 <= RESET_VAL;
            end else if (i_ce) begin
                r_q0 <= i_dout0;
            end
        end
        assign o_padout = r_q0;
    end else begin : g_out_ddr
        logic r_q0;
        logic r_q1;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_q0 <= RESET_VAL;
                r_q1 <= RESET_VAL;
            end else if (i_ce) begin
                r_q0 <= i_dout0;
                r_q1 <= i_dout1;
            end
        end
        assign o_padout = i_clk ? r_q0 : r_q1;
    end

endmodule

// File: rtl/pre_io_bank.sv
// Bank of WIDTH identical pad channels sharing one clock, enable, freeze and
// drive-enable path; illegal parameter combinations stop elaboration.
module pre_io_bank
    import pre_io_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      IN_MODE     = IN_REG,
    parameter int unsigned      OUT_MODE    = OUT_REG,
    parameter int unsigned      OE_MODE     = OE_DIRECT,
    parameter int unsigned      SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLOCKENABLE,
    input  logic             LATCHINPUTVALUE,
    input  logic             OUTPUTENABLE,
    input  logic [WIDTH-1:0] DOUT0,
    input  logic [WIDTH-1:0] DOUT1,
    output logic [WIDTH-1:0] DIN0,
    output logic [WIDTH-1:0] DIN1,
    input  logic [WIDTH-1:0] PADIN,
    output logic [WIDTH-1:0] PADOUT,
    output logic [WIDTH-1:0] PADOEN
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "pre_io_bank: WIDTH must be 1..32");
    end
    if (!mode_ok(IN_MODE) || !mode_ok(OUT_MODE) || !mode_ok(OE_MODE)) begin : g_bad_mode
        $fatal(1, "pre_io_bank: mode parameter out of range");
    end
    if (SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
        $fatal(1, "pre_io_bank: SYNC_STAGES must be 0..3");
    end
    // DDR capture samples the raw pad on both edges; a synchroniser would skew the phases.
    if (IN_MODE == IN_DDR && SYNC_STAGES > 0) begin : g_bad_ddr_sync
        $fatal(1, "pre_io_bank: IN_MODE=2 requires SYNC_STAGES=0");
    end

    if (OE_MODE == OE_REG) begin : g_oe_reg
        logic r_oe;
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_oe <= 1'b0;
            end else if (CLOCKENABLE) begin
                r_oe <= OUTPUTENABLE;
            end
        end
        assign PADOEN = {WIDTH{r_oe}};
    end else if (OE_MODE == OE_DIRECT) begin : g_oe_direct
        assign PADOEN = {WIDTH{OUTPUTENABLE}};
    end else begin : g_oe_always
        logic w_unused_oe;
        assign w_unused_oe = OUTPUTENABLE;
        assign PADOEN      = '1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        pre_io_slice #(
            .IN_MODE     (IN_MODE),
            .OUT_MODE    (OUT_MODE),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (RESET_VAL[i])
        ) u_slice (
            .i_clk    (CLK),
            .i_rst    (RST),
            .i_ce     (CLOCKENABLE),
            .i_latch  (LATCHINPUTVALUE),
            .i_dout0  (DOUT0[i]),
            .i_dout1  (DOUT1[i]),
            .i_padin  (PADIN[i]),
            .o_din0   (DIN0[i]),
            .o_din1   (DIN1[i]),
            .o_padout (PADOUT[i])
        );
    end

endmodule

// File: tb/tb_pre_io_bank.sv
// Directed bench for pre_io_bank: registered/sync, DDR and combinational
// instances share one set of stimulus and are checked against hand values.
module tb_pre_io_bank;
    import pre_io_pkg::*;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       latch;
    logic       oe;
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic [7:0] padin;

    logic [7:0] a_din0, a_din1, a_padout, a_padoen;
    logic [7:0] d_din0, d_din1, d_padout, d_padoen;
    logic [7:0] c_din0, c_din1, c_padout, c_padoen;

    int n_checks = 0;
    int n_fail   = 0;

    pre_io_bank #(
        .WIDTH(8), .IN_MODE(IN_REG), .OUT_MODE(OUT_REG), .OE_MODE(OE_REG),
        .SYNC_STAGES(2), .RESET_VAL(8'h81)
    ) u_reg (
        .CLK(clk), .RST(rst), .CLOCKENABLE(ce), .LATCHINPUTVALUE(latch),
        .OUTPUTENABLE(oe), .DOUT0(dout0), .DOUT1(dout1), .DIN0(a_din0),
        .DIN1(a_din1), .PADIN(padin), .PADOUT(a_padout), .PADOEN(a_padoen)
    );

    pre_io_bank #(
        .WIDTH(8), .IN_MODE(IN_DDR), .OUT_MODE(OUT_DDR), .OE_MODE(OE_DIRECT),
        .SYNC_STAGES(0), .RESET_VAL(8'h00)
    ) u_ddr (
        .CLK(clk), .RST(rst), .CLOCKENABLE(ce), .LATCHINPUTVALUE(latch),
        .OUTPUTENABLE(oe), .DOUT0(dout0), .DOUT1(dout1), .DIN0(d_din0),
        .DIN1(d_din1), .PADIN(padin), .PADOUT(d_padout), .PADOEN(d_padoen)
    );

    pre_io_bank #(
        .WIDTH(8), .IN_MODE(IN_COMB), .OUT_MODE(OUT_COMB), .OE_MODE(OE_ALWAYS),
        .SYNC_STAGES(0), .RESET_VAL(8'h00)
    ) u_comb (
        .CLK(clk), .RST(rst), .CLOCKENABLE(ce), .LATCHINPUTVALUE(latch),
        .OUTPUTENABLE(oe), .DOUT0(dout0), .DOUT1(dout1), .DIN0(c_din0),
        .DIN1(c_din1), .PADIN(padin), .PADOUT(c_padout), .PADOEN(c_padoen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Leaves time 2 units after a rising edge, CLK still high.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; latch = 1'b0; oe = 1'b0;
        dout0 = 8'h00; dout1 = 8'h00; padin = 8'h00;

        // Reset state
        step(); step();
        chk("rst_a_din0", a_din0, 8'h00);
        chk("rst_a_padout", a_padout, 8'h81);
        chk("rst_a_padoen", a_padoen, 8'h00);
        chk("rst_d_din0", d_din0, 8'h00);
        chk("rst_d_din1", d_din1, 8'h00);
        chk("rst_d_padout_hi", d_padout, 8'h00);
        dout0 = 8'h33; oe = 1'b1;
        #1;
        chk("rst_c_padout", c_padout, 8'h33);
        chk("rst_c_padoen", c_padoen, 8'hFF);
        chk("rst_d_padoen", d_padoen, 8'hFF);
        chk("rst_a_padoen_held", a_padoen, 8'h00);
        step();
        chk("rst_a_padout_held", a_padout, 8'h81);
        rst = 1'b0;
        #1;
        chk("rel_a_padout", a_padout, 8'h81);
        chk("rel_a_padoen", a_padoen, 8'h00);
        step();
        chk("reg_a_padout", a_padout, 8'h33);
        chk("reg_a_padoen", a_padoen, 8'hFF);

        // Two-stage synchroniser plus input register
        padin = 8'hA5;
        #1;
        chk("comb_c_din0", c_din0, 8'hA5);
        step(); chk("sync_e1", a_din0, 8'h00);
        step(); chk("sync_e2", a_din0, 8'h00);
        step(); chk("sync_e3", a_din0, 8'hA5);

        // DDR input: rise sample 3C, fall sample C3
        padin = 8'h3C;
        step();
        padin = 8'hC3;
        step();
        chk("ddr_din0", d_din0, 8'h3C);
        chk("ddr_din1", d_din1, 8'hC3);
        chk("reg_din1_zero", a_din1, 8'h00);
        chk("comb_din1_zero", c_din1, 8'h00);

        // DDR output follows CLK level
        dout0 = 8'hFF; dout1 = 8'h00;
        step();
        chk("ddr_out_hi_ff", d_padout, 8'hFF);
        chk("reg_out_ff", a_padout, 8'hFF);
        #5;
        chk("ddr_out_lo_00", d_padout, 8'h00);
        dout0 = 8'h0F; dout1 = 8'hF0;
        step();
        chk("ddr_out_hi_0f", d_padout, 8'h0F);
        #5;
        chk("ddr_out_lo_f0", d_padout, 8'hF0);

        // Input freeze
        padin = 8'h5A;
        step(); step(); step();
        chk("latch_pre", a_din0, 8'h5A);
        latch = 1'b1;
        padin = 8'hFF;
        #1;
        chk("latch_c_hold", c_din0, 8'h5A);
        step(); chk("latch_t1", a_din0, 8'h5A);
        padin = 8'h00;
        step(); chk("latch_t2", a_din0, 8'h5A);
        padin = 8'hFF;
        step(); chk("latch_t3", a_din0, 8'h5A);
        padin = 8'h00;
        step(); chk("latch_t4", a_din0, 8'h5A);
        chk("latch_c_t4", c_din0, 8'h5A);
        latch = 1'b0;
        #1;
        chk("release_c_live", c_din0, 8'h00);
        step();
        chk("release_a_live", a_din0, 8'hFF);

        // Clock enable freeze, then reset overriding it
        dout0 = 8'h11;
        step();
        chk("ce_pre", a_padout, 8'h11);
        ce = 1'b0; dout0 = 8'h22; oe = 1'b0;
        #1;
        chk("ce_d_padoen", d_padoen, 8'h00);
        chk("ce_c_padoen", c_padoen, 8'hFF);
        step();
        chk("ce_hold1", a_padout, 8'h11);
        chk("ce_oe_hold", a_padoen, 8'hFF);
        dout0 = 8'h44;
        step(); chk("ce_hold2", a_padout, 8'h11);
        dout0 = 8'h88;
        step(); chk("ce_hold3", a_padout, 8'h11);
        chk("ce_c_live", c_padout, 8'h88);
        rst = 1'b1;
        step();
        chk("ce_rst_padout", a_padout, 8'h81);
        chk("ce_rst_padoen", a_padoen, 8'h00);
        chk("ce_rst_din0", a_din0, 8'h00);
        chk("ce_rst_d_din0", d_din0, 8'h00);
        chk("ce_rst_d_din1", d_din1, 8'h00);
        rst = 1'b0; ce = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
